// File: rtl/gpr_wr_arb.sv
// gpr_wr_arb: arbitrates the single GPR write port between the writeback
// stage (requester 0) and the multiply/divide unit (requester 1).
// Each requester feeds a one-entry holding register over valid/ready; one
// granted entry per cycle is written to a registered GPR write port.
//
// Optional feature macro: GPR_WR_ARB_RR_EN
//   defined     : round-robin between requesters on different-id contention
//   not defined : fixed priority, requester 0 wins
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_reqN_valid/o_reqN_ready    handshake for requester N (0 or 1)
//   i_reqN_id/i_reqN_data        destination GPR and write data
//   o_gpr_wr_en/id/data          registered GPR write port
//   o_pend_mask                  GPRs with a write held or being driven
module gpr_wr_arb #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_req0_valid,
    output logic                    o_req0_ready,
    input  logic [ID_W-1:0]         i_req0_id,
    input  logic [DATA_W-1:0]       i_req0_data,
    input  logic                    i_req1_valid,
    output logic                    o_req1_ready,
    input  logic [ID_W-1:0]         i_req1_id,
    input  logic [DATA_W-1:0]       i_req1_data,
    output logic                    o_gpr_wr_en,
    output logic [ID_W-1:0]         o_gpr_wr_id,
    output logic [DATA_W-1:0]       o_gpr_wr_data,
    output logic [(1<<ID_W)-1:0]    o_pend_mask
);

    localparam int unsigned NREG = 1 << ID_W;

    // holding registers and age bits
    logic              r_full0, r_full1;
    logic [ID_W-1:0]   r_id0, r_id1;
    logic [DATA_W-1:0] r_data0, r_data1;
    logic              r_older0, r_older1;

    // output port registers
    logic              r_wr_en;
    logic [ID_W-1:0]   r_wr_id;
    logic [DATA_W-1:0] r_wr_data;

    logic              w_grant0, w_grant1;
    logic              w_load0, w_load1;
    logic [NREG-1:0]   w_pend_mask;

`ifdef GPR_WR_ARB_RR_EN
    logic              r_rr_ptr;      // 0: requester 0 preferred on next contested grant
    logic              w_contested;
`endif

    // grant selection over the full entries
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
`ifdef GPR_WR_ARB_RR_EN
        w_contested = 1'b0;
`endif
        if (r_full0 && r_full1) begin
            if (r_id0 == r_id1) begin
                // same destination: oldest first, same-cycle loads go to requester 0
                if (r_older1 && !r_older0) w_grant1 = 1'b1;
                else                       w_grant0 = 1'b1;
            end else begin
`ifdef GPR_WR_ARB_RR_EN
                w_contested = 1'b1;
                if (r_rr_ptr) w_grant1 = 1'b1;
                else          w_grant0 = 1'b1;
`else
                w_grant0 = 1'b1;
`endif
            end
        end else if (r_full0) begin
            w_grant0 = 1'b1;
        end else if (r_full1) begin
            w_grant1 = 1'b1;
        end
    end

    assign o_req0_ready = !r_full0 || w_grant0;
    assign o_req1_ready = !r_full1 || w_grant1;

    // writes to x0 complete the handshake but never occupy an entry
    assign w_load0 = i_req0_valid && o_req0_ready && (i_req0_id != '0);
    assign w_load1 = i_req1_valid && o_req1_ready && (i_req1_id != '0);

    // entry, output port and pointer state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_full0   <= 1'b0;
            r_full1   <= 1'b0;
            r_id0     <= '0;
            r_id1     <= '0;
            r_data0   <= '0;
            r_data1   <= '0;
            r_older0  <= 1'b0;
            r_older1  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_id   <= '0;
            r_wr_data <= '0;
`ifdef GPR_WR_ARB_RR_EN
            r_rr_ptr  <= 1'b0;
`endif
        end else begin
            if (w_grant0) r_full0 <= 1'b0;
            if (w_grant1) r_full1 <= 1'b0;

            // a new entry is older only against an empty or departing neighbour;
            // a surviving entry becomes older once its neighbour departs
            if (w_load0) begin
                r_full0  <= 1'b1;
                r_id0    <= i_req0_id;
                r_data0  <= i_req0_data;
                r_older0 <= !r_full1 || w_grant1;
            end else if (w_grant1) begin
                r_older0 <= 1'b1;
            end

            if (w_load1) begin
                r_full1  <= 1'b1;
                r_id1    <= i_req1_id;
                r_data1  <= i_req1_data;
                r_older1 <= !r_full0 || w_grant0;
            end else if (w_grant0) begin
                r_older1 <= 1'b1;
            end

            r_wr_en <= w_grant0 || w_grant1;
            if (w_grant0) begin
                r_wr_id   <= r_id0;
                r_wr_data <= r_data0;
            end else if (w_grant1) begin
                r_wr_id   <= r_id1;
                r_wr_data <= r_data1;
            end

`ifdef GPR_WR_ARB_RR_EN
            if (w_contested) r_rr_ptr <= w_grant0;
`endif
        end
    end

    // pending-destination mask from held entries and the in-flight write
    always_comb begin
        w_pend_mask = '0;
        if (r_full0) w_pend_mask[r_id0]   = 1'b1;
        if (r_full1) w_pend_mask[r_id1]   = 1'b1;
        if (r_wr_en) w_pend_mask[r_wr_id] = 1'b1;
        w_pend_mask[0] = 1'b0;
    end

    assign o_gpr_wr_en   = r_wr_en;
    assign o_gpr_wr_id   = r_wr_id;
    assign o_gpr_wr_data = r_wr_data;
    assign o_pend_mask   = w_pend_mask;

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Scoreboard bench for gpr_wr_arb: a transaction-level model predicts grants,
// ready and the pending mask; a monitor checks every GPR write it observes.
module tb_gpr_wr_arb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned NREG   = 1 << ID_W;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_req0_valid, i_req1_valid;
    logic              o_req0_ready, o_req1_ready;
    logic [ID_W-1:0]   i_req0_id, i_req1_id;
    logic [DATA_W-1:0] i_req0_data, i_req1_data;
    logic              o_gpr_wr_en;
    logic [ID_W-1:0]   o_gpr_wr_id;
    logic [DATA_W-1:0] o_gpr_wr_data;
    logic [NREG-1:0]   o_pend_mask;

    gpr_wr_arb #(.DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
        .i_req0_id(i_req0_id), .i_req0_data(i_req0_data),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
        .i_req1_id(i_req1_id), .i_req1_data(i_req1_data),
        .o_gpr_wr_en(o_gpr_wr_en), .o_gpr_wr_id(o_gpr_wr_id),
        .o_gpr_wr_data(o_gpr_wr_data), .o_pend_mask(o_pend_mask)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: one slot per requester, age is the load cycle number
    logic              m_full [2];
    logic [ID_W-1:0]   m_id   [2];
    logic [DATA_W-1:0] m_data [2];
    int                m_ts   [2];
    int                m_ptr;
    logic              m_out_en;
    logic [ID_W-1:0]   m_out_id;
    int                m_cyc;

    logic [ID_W-1:0]   exp_id[$];
    logic [DATA_W-1:0] exp_data[$];
    logic [ID_W-1:0]   log_id[$];
    logic [DATA_W-1:0] log_data[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_full[n] = 1'b0; m_id[n] = '0; m_data[n] = '0; m_ts[n] = 0;
        end
        m_ptr = 0; m_out_en = 1'b0; m_out_id = '0;
        exp_id.delete(); exp_data.delete();
    endtask

    // one cycle of the model; called mid-cycle after inputs are driven
    task automatic model_cycle();
        int g;
        logic [NREG-1:0] mask;
        logic rdy [2];
        logic vld [2];
        logic [ID_W-1:0] nid [2];
        logic [DATA_W-1:0] ndat [2];
        vld[0] = i_req0_valid; nid[0] = i_req0_id; ndat[0] = i_req0_data;
        vld[1] = i_req1_valid; nid[1] = i_req1_id; ndat[1] = i_req1_data;

        mask = '0;
        for (int n = 0; n < 2; n++) if (m_full[n]) mask[m_id[n]] = 1'b1;
        if (m_out_en) mask[m_out_id] = 1'b1;
        chk("pend_mask", 64'(o_pend_mask), 64'(mask));

        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_id[0] == m_id[1]) begin
                g = (m_ts[1] < m_ts[0]) ? 1 : 0;
            end else begin
`ifdef GPR_WR_ARB_RR_EN
                g = m_ptr;
                m_ptr = 1 - g;
`else
                g = 0;
`endif
            end
        end else if (m_full[0]) g = 0;
        else if (m_full[1]) g = 1;

        for (int n = 0; n < 2; n++) rdy[n] = !m_full[n] || (g == n);
        chk("req0_ready", 64'(o_req0_ready), 64'(rdy[0]));
        chk("req1_ready", 64'(o_req1_ready), 64'(rdy[1]));

        if (g >= 0) begin
            exp_id.push_back(m_id[g]);
            exp_data.push_back(m_data[g]);
            m_full[g] = 1'b0;
            m_out_en = 1'b1;
            m_out_id = m_id[g];
        end else begin
            m_out_en = 1'b0;
        end

        for (int n = 0; n < 2; n++) begin
            if (vld[n] && rdy[n] && nid[n] != '0) begin
                m_full[n] = 1'b1; m_id[n] = nid[n]; m_data[n] = ndat[n]; m_ts[n] = m_cyc;
            end
        end
        m_cyc++;
    endtask

    task automatic step(input logic v0, input logic [ID_W-1:0] id0, input logic [DATA_W-1:0] d0,
                        input logic v1, input logic [ID_W-1:0] id1, input logic [DATA_W-1:0] d1);
        @(negedge i_clk);
        i_req0_valid = v0; i_req0_id = id0; i_req0_data = d0;
        i_req1_valid = v1; i_req1_id = id1; i_req1_data = d1;
        #1;
        model_cycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_req0_valid = 1'b0; i_req1_valid = 1'b0;
        #2 i_rst = 1'b1;
        model_reset();
        #1;
        chk("rst_wr_en",   64'(o_gpr_wr_en), 64'd0);
        chk("rst_wr_id",   64'(o_gpr_wr_id), 64'd0);
        chk("rst_wr_data", 64'(o_gpr_wr_data), 64'd0);
        chk("rst_mask",    64'(o_pend_mask), 64'd0);
        chk("rst_ready0",  64'(o_req0_ready), 64'd1);
        chk("rst_ready1",  64'(o_req1_ready), 64'd1);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // monitor: every observed write must match the oldest predicted write
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (o_gpr_wr_en === 1'b1) begin
                log_id.push_back(o_gpr_wr_id);
                log_data.push_back(o_gpr_wr_data);
                if (exp_id.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got id %0d data %0h expected none", o_gpr_wr_id, o_gpr_wr_data);
                end else begin
                    chk("wr_id",   64'(o_gpr_wr_id),   64'(exp_id.pop_front()));
                    chk("wr_data", 64'(o_gpr_wr_data), 64'(exp_data.pop_front()));
                end
            end
        end
    end

    initial begin
        i_rst = 1'b1;
        i_req0_valid = 1'b0; i_req0_id = '0; i_req0_data = '0;
        i_req1_valid = 1'b0; i_req1_id = '0; i_req1_data = '0;
        m_cyc = 0;
        model_reset();
        #3;
        chk("init_wr_en", 64'(o_gpr_wr_en), 64'd0);
        chk("init_mask",  64'(o_pend_mask), 64'd0);
        chk("init_ready0", 64'(o_req0_ready), 64'd1);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // single write: mask in cycles 2-3, write in cycle 3
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        idle(1);
        chk("single_en_c2",   64'(o_gpr_wr_en), 64'd0);
        chk("single_mask_c2", 64'(o_pend_mask), 64'h8);
        idle(1);
        chk("single_en_c3",   64'(o_gpr_wr_en), 64'd1);
        chk("single_id_c3",   64'(o_gpr_wr_id), 64'd3);
        chk("single_data_c3", 64'(o_gpr_wr_data), 64'hDEADBEEF);
        chk("single_mask_c3", 64'(o_pend_mask), 64'h8);
        idle(2);

        // write to x0 is dropped
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
        chk("x0_ready", 64'(o_req1_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            idle(1);
            chk("x0_en",   64'(o_gpr_wr_en), 64'd0);
            chk("x0_mask", 64'(o_pend_mask), 64'd0);
        end

        // back-to-back throughput on requester 0
        log_id.delete(); log_data.delete();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, ID_W'(k % 7 + 1), DATA_W'(32'h100 + k), 1'b0, '0, '0);
            chk("b2b_ready0", 64'(o_req0_ready), 64'd1);
        end
        idle(3);
        chk("b2b_count", 64'(log_id.size()), 64'd8);

        // same-id ordering across requesters
        log_id.delete(); log_data.delete();
        step(1'b0, '0, '0, 1'b1, 5'd7, 32'hA);
        step(1'b1, 5'd7, 32'hB, 1'b0, '0, '0);
        idle(4);
        chk("sameid_count", 64'(log_id.size()), 64'd2);
        if (log_data.size() == 2) begin
            chk("sameid_first", 64'(log_data[0]), 64'hA);
            chk("sameid_final", 64'(log_data[1]), 64'hB);
        end

        // reset with both entries full, then nothing must be written
        step(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66);
        do_reset();
        idle(4);

        // contention with different ids, pointer starts at requester 0
        log_id.delete(); log_data.delete();
        for (int k = 0; k < 6; k++) step(1'b1, 5'd5, DATA_W'(k), 1'b1, 5'd6, DATA_W'(k + 16));
        idle(6);
        if (log_id.size() >= 4) begin
`ifdef GPR_WR_ARB_RR_EN
            chk("cont_w0", 64'(log_id[0]), 64'd5);
            chk("cont_w1", 64'(log_id[1]), 64'd6);
            chk("cont_w2", 64'(log_id[2]), 64'd5);
            chk("cont_w3", 64'(log_id[3]), 64'd6);
`else
            chk("cont_w0", 64'(log_id[0]), 64'd5);
            chk("cont_w1", 64'(log_id[1]), 64'd5);
            chk("cont_w2", 64'(log_id[2]), 64'd5);
            chk("cont_w3", 64'(log_id[3]), 64'd5);
`endif
        end else begin
            chk("cont_count", 64'(log_id.size()), 64'd4);
        end

        // random traffic over a small id range to provoke collisions and x0
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 9) < 6), ID_W'($urandom_range(0, 4)), DATA_W'($urandom),
                 ($urandom_range(0, 9) < 5), ID_W'($urandom_range(0, 4)), DATA_W'($urandom));
        end
        idle(6);
        chk("scoreboard_drain", 64'(exp_id.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wr_arb.md
# gpr_wr_arb

Arbiter and sequencer for the single GPR write port of the L2 core. It merges the in-order writeback stream from the writeback stage (requester 0) with the out-of-order result stream from the long-latency multiply/divide unit (requester 1). Each requester has a one-entry holding register behind a valid/ready handshake. One write per cycle is granted to a registered GPR write port, and a pending-destination mask is exported for hazard detection.

## Interface
Parameters:
- DATA_W, 32, write data width
- ID_W, 5, GPR index width; register file has 2**ID_W entries

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_req0_valid  in  1  writeback-stage write request
- o_req0_ready  out  1  requester 0 may hand over this cycle
- i_req0_id  in  ID_W  destination GPR
- i_req0_data  in  DATA_W  write data
- i_req1_valid, o_req1_ready, i_req1_id, i_req1_data: same as requester 0, for the multiply/divide unit
- o_gpr_wr_en  out  1  registered GPR write enable
- o_gpr_wr_id  out  ID_W  registered GPR write index
- o_gpr_wr_data  out  DATA_W  registered GPR write data
- o_pend_mask  out  2**ID_W  bit k set while a write to GPR k is held or being driven

## Operation
- Accept on requester n = i_reqn_valid && o_reqn_ready at the rising edge.
- Accept with id 0: completes the handshake but is discarded. Holding register stays empty, no write is issued, no mask bit is set.
- Accept with nonzero id: loads holding register n (full_n=1, id, data). Sets age bit older_n=1 iff the other entry is empty or is being granted in the same cycle.
- o_reqn_ready = !full_n || grant_n, so each requester sustains 1 write/cycle while uncontested.
- Grant, combinational over the full entries:
  - Only one entry full: grant it.
  - Both full, equal ids: grant the older entry. If loaded in the same cycle, grant requester 0.
  - Both full, different ids: policy per Configuration.
- On the grant edge the entry is freed. The output register loads en=1 with the granted id/data. If there is no grant, en=0 and id/data hold their previous values.
- o_pend_mask = decode(id0)&full0 | decode(id1)&full1 | decode(o_gpr_wr_id)&o_gpr_wr_en. Bit 0 is never set.

## Timing
- Reset values: all entries empty, age bits 0, RR pointer = requester 0, o_gpr_wr_en=0, o_gpr_wr_id=0, o_gpr_wr_data=0, o_pend_mask=0. Ready outputs are 1 once reset is asserted.
- Reset asserted mid-operation: held entries and the in-flight output are dropped immediately (asynchronous). No write is issued.
- Latency: accept at edge N, grant during cycle N+1, o_gpr_wr_en=1 during cycle N+2.
- Contention: the losing entry keeps its data and its ready stays 0. It is granted on a later cycle; the worst-case wait depends on the policy.
- Simultaneous grant and reload of the same entry: the freed slot is refilled on the same edge and the new entry's age is computed against the post-grant state.
- o_gpr_wr_en is never high for two different ids in one cycle.
- All handshake outputs depend only on registered state plus the grant. There is no combinational path from i_reqn_valid to o_reqn_ready.

## Configuration
- GPR_WR_ARB_RR_EN defined: round-robin between requesters when both are full with different ids. The pointer toggles to the other requester after each contested grant. Worst-case wait is 1 cycle.
- Not defined: fixed priority, requester 0 wins. Requester 1 may wait indefinitely while requester 0 streams back-to-back.
- The same-id age rule applies in both modes.

## Test plan
- Single write: req0 id=3 data=0xDEADBEEF at edge 1 -> o_gpr_wr_en=1, id=3, data=0xDEADBEEF in cycle 3; o_pend_mask=0x8 in cycles 2-3.
- x0 drop: req1 id=0 data=0x1234 -> ready=1, o_gpr_wr_en stays 0, o_pend_mask stays 0.
- Contention, different ids, RR on: both valid every cycle with ids 5/6 -> writes alternate 5,6,5,6… starting with req0. With the macro off, only id 5 is written while req0 streams.
- Same-id ordering: req1 id=7 data=0xA accepted 1 cycle before req0 id=7 data=0xB -> writes in order 0xA then 0xB; final value 0xB.
- Back-to-back throughput: req0 valid for 8 cycles, req1 idle -> 8 consecutive writes, ready never low.
- Reset mid-flight: both entries full, assert i_rst -> all outputs 0 asynchronously, no write issued after release.
